// File: rtl/multiplier_arbiter_taint_track.sv
// multiplier_arbiter_taint_track: round-robin sharing of one sequential
// multiplier between two requesters, with word-level taint on every output.
module multiplier_arbiter_taint_track #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 2*WIDTH+4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req0_t,
  input  logic [WIDTH-1:0]   req0_multiplier,
  input  logic               req0_multiplier_t,
  input  logic [WIDTH-1:0]   req0_multiplicand,
  input  logic               req0_multiplicand_t,
  input  logic               req1,
  input  logic               req1_t,
  input  logic [WIDTH-1:0]   req1_multiplier,
  input  logic               req1_multiplier_t,
  input  logic [WIDTH-1:0]   req1_multiplicand,
  input  logic               req1_multiplicand_t,
  output logic               ack0,
  output logic               ack0_t,
  output logic               ack1,
  output logic               ack1_t,
  output logic               resp0_valid,
  output logic               resp0_valid_t,
  output logic               resp1_valid,
  output logic               resp1_valid_t,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               resp_product_t,
  output logic               resp_err,
  output logic               mul_start,
  output logic               mul_start_t,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic               mul_multiplier_t,
  output logic               mul_multiplicand_t,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_product_t,
  input  logic               mul_done,
  input  logic               mul_done_t,
  output logic               busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic any_req;
  logic win;
  logic in_t;
  logic timeout;

  logic               w_q;
  logic               dt_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic               op_a_t_q;
  logic               op_b_t_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               pt_q;
  logic               vt_q;
  logic               err_q;
  logic               prio_q;
  logic [CW-1:0]      cnt_q;

  assign any_req = req0 | req1;
  assign win     = req1 & (~req0 | prio_q);
  assign in_t    = req0_t | req1_t;
  // Fires on the WAIT cycle whose increment brings the count to TIMEOUT.
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    ack0               = 1'b0;
    ack0_t             = 1'b0;
    ack1               = 1'b0;
    ack1_t             = 1'b0;
    resp0_valid        = 1'b0;
    resp0_valid_t      = 1'b0;
    resp1_valid        = 1'b0;
    resp1_valid_t      = 1'b0;
    resp_product       = '0;
    resp_product_t     = 1'b0;
    resp_err           = 1'b0;
    mul_start          = 1'b0;
    mul_start_t        = 1'b0;
    mul_multiplier     = '0;
    mul_multiplicand   = '0;
    mul_multiplier_t   = 1'b0;
    mul_multiplicand_t = 1'b0;
    busy               = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          ack0_t = in_t;
          ack1_t = in_t;
          if (any_req) begin
            ack0      = ~win;
            ack1      = win;
            state_nxt = START;
          end
        end
        START: begin
          mul_start   = 1'b1;
          mul_start_t = dt_q;
          state_nxt   = WAIT;
        end
        WAIT: begin
          if (mul_done || timeout) begin
            state_nxt = RESP;
          end
        end
        RESP: begin
          resp0_valid    = ~w_q;
          resp1_valid    = w_q;
          resp0_valid_t  = vt_q;
          resp1_valid_t  = vt_q;
          resp_product   = prod_q;
          resp_product_t = pt_q;
          resp_err       = err_q;
          state_nxt      = IDLE;
        end
      endcase
      if (state != IDLE) begin
        busy               = 1'b1;
        mul_multiplier     = op_a_q;
        mul_multiplicand   = op_b_q;
        mul_multiplier_t   = op_a_t_q | dt_q;
        mul_multiplicand_t = op_b_t_q | dt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= 1'b0;
      dt_q     <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_a_t_q <= 1'b0;
      op_b_t_q <= 1'b0;
      prod_q   <= '0;
      pt_q     <= 1'b0;
      vt_q     <= 1'b0;
      err_q    <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            w_q      <= win;
            dt_q     <= in_t;
            op_a_q   <= win ? req1_multiplier
                            : req0_multiplier;
            op_b_q   <= win ? req1_multiplicand
                            : req0_multiplicand;
            op_a_t_q <= win ? req1_multiplier_t
                            : req0_multiplier_t;
            op_b_t_q <= win ? req1_multiplicand_t
                            : req0_multiplicand_t;
          end
        end
        START: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
          // A done on the timeout cycle still counts as success.
          if (mul_done) begin
            prod_q <= mul_product;
            pt_q   <= mul_product_t | dt_q;
            vt_q   <= mul_done_t | dt_q;
            err_q  <= 1'b0;
          end else if (timeout) begin
            prod_q <= '0;
            pt_q   <= dt_q;
            vt_q   <= mul_done_t | dt_q;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          prio_q <= ~w_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter_taint_track.sv
// tb_multiplier_arbiter_taint_track: random scoreboard bench with a
// transaction-level model of arbitration, multiply, timeout and taint.
module tb_multiplier_arbiter_taint_track;

  localparam int W  = 4;
  localparam int T  = 2*W+4;
  localparam int PW = 2*W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, req0_t;
  logic [W-1:0]  req0_multiplier, req0_multiplicand;
  logic          req0_multiplier_t, req0_multiplicand_t;
  logic          req1, req1_t;
  logic [W-1:0]  req1_multiplier, req1_multiplicand;
  logic          req1_multiplier_t, req1_multiplicand_t;
  logic          ack0, ack0_t, ack1, ack1_t;
  logic          resp0_valid, resp0_valid_t;
  logic          resp1_valid, resp1_valid_t;
  logic [PW-1:0] resp_product;
  logic          resp_product_t, resp_err;
  logic          mul_start, mul_start_t;
  logic [W-1:0]  mul_multiplier, mul_multiplicand;
  logic          mul_multiplier_t, mul_multiplicand_t;
  logic [PW-1:0] mul_product;
  logic          mul_product_t, mul_done, mul_done_t;
  logic          busy;

  multiplier_arbiter_taint_track #(
    .WIDTH(W),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .req0_t(req0_t),
    .req0_multiplier(req0_multiplier),
    .req0_multiplier_t(req0_multiplier_t),
    .req0_multiplicand(req0_multiplicand),
    .req0_multiplicand_t(req0_multiplicand_t),
    .req1(req1),
    .req1_t(req1_t),
    .req1_multiplier(req1_multiplier),
    .req1_multiplier_t(req1_multiplier_t),
    .req1_multiplicand(req1_multiplicand),
    .req1_multiplicand_t(req1_multiplicand_t),
    .ack0(ack0),
    .ack0_t(ack0_t),
    .ack1(ack1),
    .ack1_t(ack1_t),
    .resp0_valid(resp0_valid),
    .resp0_valid_t(resp0_valid_t),
    .resp1_valid(resp1_valid),
    .resp1_valid_t(resp1_valid_t),
    .resp_product(resp_product),
    .resp_product_t(resp_product_t),
    .resp_err(resp_err),
    .mul_start(mul_start),
    .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand),
    .mul_multiplier_t(mul_multiplier_t),
    .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product),
    .mul_product_t(mul_product_t),
    .mul_done(mul_done),
    .mul_done_t(mul_done_t),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            w;
    logic [PW-1:0] prod;
    bit            err;
    bit            pt;
    bit            vt;
    int            at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  bit           p_v  [2];
  logic [W-1:0] p_a  [2];
  logic [W-1:0] p_b  [2];
  bit           p_t  [2];
  bit           p_at [2];
  bit           p_bt [2];
  bit           prio_m;

  wire [30:0] all_out = {
    ack0, ack0_t, ack1, ack1_t,
    resp0_valid, resp0_valid_t,
    resp1_valid, resp1_valid_t,
    resp_product, resp_product_t, resp_err,
    mul_start, mul_start_t,
    mul_multiplier, mul_multiplicand,
    mul_multiplier_t, mul_multiplicand_t,
    busy
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    req0                = p_v[0];
    req0_t              = p_v[0] & p_t[0];
    req0_multiplier     = p_v[0] ? p_a[0] : '0;
    req0_multiplicand   = p_v[0] ? p_b[0] : '0;
    req0_multiplier_t   = p_v[0] & p_at[0];
    req0_multiplicand_t = p_v[0] & p_bt[0];
    req1                = p_v[1];
    req1_t              = p_v[1] & p_t[1];
    req1_multiplier     = p_v[1] ? p_a[1] : '0;
    req1_multiplicand   = p_v[1] ? p_b[1] : '0;
    req1_multiplier_t   = p_v[1] & p_at[1];
    req1_multiplicand_t = p_v[1] & p_bt[1];
  endtask

  task automatic add_req(input int n,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input bit t,
                         input bit at,
                         input bit bt);
    if (!p_v[n]) begin
      p_v[n]  = 1'b1;
      p_a[n]  = a;
      p_b[n]  = b;
      p_t[n]  = t;
      p_at[n] = at;
      p_bt[n] = bt;
    end
  endtask

  task automatic add_rand(input int n);
    add_req(n, W'($urandom), W'($urandom),
            $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0);
  endtask

  // k = WAIT cycle carrying done (0: never, timeout expected).
  // rst_at = WAIT cycle in which reset is applied (0: none).
  task automatic txn(input int k,
                     input bit stale,
                     input bit busy_req,
                     input int rst_at,
                     input bit mpt,
                     input bit mdt);
    bit           w, dt, to, at, bt;
    int           c0, rj, o;
    logic [W-1:0] a, b;
    exp_t         e;
    drive_reqs();
    mul_done      = stale;
    mul_product   = PW'($urandom);
    mul_product_t = mpt;
    mul_done_t    = mdt;
    #1;
    dt = (p_v[0] & p_t[0]) | (p_v[1] & p_t[1]);
    chk("ack0_t", 32'(ack0_t), 32'(dt));
    chk("ack1_t", 32'(ack1_t), 32'(dt));
    if (!p_v[0] && !p_v[1]) begin
      chk("idle_no_ack", 32'({ack0, ack1}), 32'(0));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
      return;
    end
    w = (p_v[0] && p_v[1]) ? prio_m : p_v[1];
    o = w ? 0 : 1;
    chk("ack0", 32'(ack0), 32'(!w));
    chk("ack1", 32'(ack1), 32'(w));
    a  = p_a[w];
    b  = p_b[w];
    at = p_at[w];
    bt = p_bt[w];
    to = (k == 0);
    c0 = cyc;
    rj = to ? T + 1 : k + 1;
    e.w    = w;
    e.prod = to ? '0 : PW'(a) * PW'(b);
    e.err  = to;
    e.pt   = to ? dt : (mpt | dt);
    e.vt   = mdt | dt;
    e.at   = c0 + 1 + rj;
    sb.push_back(e);
    @(negedge clk);
    p_v[w] = 1'b0;
    drive_reqs();
    mul_done    = stale;
    mul_product = PW'($urandom);
    chk("start", 32'({mul_start, mul_start_t, busy}),
        32'({1'b1, dt, 1'b1}));
    chk("operands", 32'({mul_multiplier, mul_multiplicand}),
        32'({a, b}));
    chk("operand_t", 32'({mul_multiplier_t, mul_multiplicand_t}),
        32'({at | dt, bt | dt}));
    for (int j = 1; j <= rj; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        rst      = 1'b1;
        p_v[0]   = 1'b0;
        p_v[1]   = 1'b0;
        mul_done = 1'b0;
        drive_reqs();
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst    = 1'b0;
        prio_m = 1'b0;
        #1;
        chk("reset_mid_outputs", 32'(all_out), 32'(0));
        return;
      end
      mul_done = (j == k);
      if (j == k) begin
        mul_product = PW'(mul_multiplier) * PW'(mul_multiplicand);
      end
      if (busy_req && j == 1) begin
        add_rand(o);
        drive_reqs();
      end
    end
    mul_done = 1'b0;
    @(negedge clk);
    chk("idle_after_resp", 32'(busy), 32'(0));
    prio_m = !w;
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (busy) begin
        chk("ack_while_busy", 32'({ack0, ack1}), 32'(0));
      end
      if (resp0_valid || resp1_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got valid=%b%b expected none",
                   resp1_valid, resp0_valid);
        end else begin
          m_e = sb.pop_front();
          chk("resp_who", 32'({resp1_valid, resp0_valid}),
              32'(m_e.w ? 2'b10 : 2'b01));
          chk("resp_product", 32'(resp_product), 32'(m_e.prod));
          chk("resp_err", 32'(resp_err), 32'(m_e.err));
          chk("resp_product_t", 32'(resp_product_t), 32'(m_e.pt));
          chk("resp_valid_t",
              32'(m_e.w ? resp1_valid_t : resp0_valid_t),
              32'(m_e.vt));
          chk("resp_cycle", 32'(cyc), 32'(m_e.at));
        end
      end else begin
        chk("quiet_resp", 32'({resp_product, resp_product_t, resp_err,
                              resp0_valid_t, resp1_valid_t}), 32'(0));
      end
    end
  end

  initial begin
    int k, rj, ra;
    rst           = 1'b1;
    mul_done      = 1'b0;
    mul_done_t    = 1'b0;
    mul_product   = '0;
    mul_product_t = 1'b0;
    prio_m        = 1'b0;
    p_v[0]        = 1'b0;
    p_v[1]        = 1'b0;
    drive_reqs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", 32'(all_out), 32'(0));

    add_req(0, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
    txn(3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(1, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    add_req(1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
    txn(4, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd6, 4'd11, 1'b0, 1'b0, 1'b0);
    add_req(1, 4'd9, 4'd13, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd10, 4'd3, 1'b0, 1'b0, 1'b0);
    add_req(1, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0);
    txn(3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd13, 4'd12, 1'b0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd15, 4'd14, 1'b0, 1'b0, 1'b0);
    txn(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(1, 4'd11, 4'd9, 1'b0, 1'b0, 1'b0);
    txn(T, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(0, 4'd4, 4'd8, 1'b0, 1'b0, 1'b0);
    txn(3, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add_req(1, 4'd12, 4'd5, 1'b0, 1'b0, 1'b0);
    txn(6, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    add_req(0, 4'd1, 4'd14, 1'b0, 1'b0, 1'b0);
    add_req(1, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1, 0) == 1) add_rand(0);
      if ($urandom_range(1, 0) == 1) add_rand(1);
      if ($urandom_range(9, 0) == 0) k = 0;
      else if ($urandom_range(4, 0) == 0) k = T;
      else k = $urandom_range(T, 1);
      rj = (k == 0) ? T + 1 : k + 1;
      ra = ($urandom_range(19, 0) == 0) ?
           $urandom_range(rj - 1, 1) : 0;
      txn(k, $urandom_range(3, 0) == 0,
          $urandom_range(3, 0) == 0, ra,
          $urandom_range(3, 0) == 0,
          $urandom_range(3, 0) == 0);
    end

    repeat (3) txn(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
